// File: rtl/cpu_defs_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs_pkg
// Shared definitions for the multicycle MIPS core's coprocessor 0:
//   - CP0 register indices (instruction rd field values)
//   - bit positions inside the SR and Cause words
//   - a helper that assembles the SR read word from its fields
// ---------------------------------------------------------------------------
package cpu_defs_pkg;

    // CP0 register indices
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    // Field positions inside SR / Cause
    localparam int IM_LSB  = 10;   // IM (SR) and IP (Cause) start here
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int TI_BIT  = 30;   // timer pending flag, Cause only

    // Builds the 32-bit SR view; unimplemented bits read as zero.
    function automatic logic [31:0] sr_word(input logic [5:0] im,
                                            input logic       exl,
                                            input logic       ie);
        logic [31:0] w;
        w                  = '0;
        w[IM_LSB +: 6]     = im;
        w[EXL_BIT]         = exl;
        w[IE_BIT]          = ie;
        return w;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// ---------------------------------------------------------------------------
// cp0_timer
// Count / Compare pair with the TI pending flag. Only built when the
// CP0_TIMER_EN macro is defined (instantiated from cp0_regfile).
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous, active-high reset
//   count_we    in   MTC0 write to Count this cycle
//   compare_we  in   MTC0 write to Compare this cycle
//   din         in   32-bit MTC0 write data
//   count       out  current Count value
//   compare     out  current Compare value
//   ti          out  timer interrupt pending flag
// ---------------------------------------------------------------------------
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] din,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic [31:0] count_nxt;
    logic        ti_q;

    // A Count write wins over the free-running increment; the increment
    // wraps naturally at 32'hFFFF_FFFF.
    always_comb begin
        count_nxt = count_q + 32'd1;
        if (count_we) begin
            count_nxt = din;
        end
    end

    // TI is raised on the same edge at which Count becomes equal to Compare,
    // so it is visible in the cycle where Count == Compare. Compare == 0
    // disables the match. Writing Compare acknowledges the interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            count_q <= count_nxt;
            if (compare_we) begin
                compare_q <= din;
                ti_q      <= 1'b0;
            end else if ((count_nxt == compare_q) && (compare_q != 32'd0)) begin
                ti_q <= 1'b1;
            end
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// ---------------------------------------------------------------------------
// cp0_regfile
// Coprocessor 0 for the multicycle MIPS core: SR, Cause, EPC and PRId, plus
// the interrupt request combine feeding the main controller.
// Optional timer (Count/Compare/TI) is built when CP0_TIMER_EN is defined.
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous, active-high reset
//   we      in   MTC0 write strobe (controller cp0_wen)
//   addr    in   CP0 register index (rd field)
//   din     in   MTC0 write data (GPR rt)
//   pc      in   PC[31:2] of the next instruction to execute
//   hwint   in   level-sensitive device interrupt requests
//   exlset  in   exception entry strobe (controller S10)
//   exlclr  in   ERET strobe
//   dout    out  MFC0 read data (combinational, zero latency)
//   epc     out  EPC[31:2], PC load value for ERET
//   intreq  out  interrupt request to the controller
//
// Control interface: we, exlset and exlclr are single-cycle strobes from the
// controller, each acting only at the rising clk edge where it is high. There
// is no back-pressure; every strobe is accepted.
// ---------------------------------------------------------------------------
module cp0_regfile
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] PRID_VAL = 32'h0002_0203,
    parameter int          HWINT_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [4:0]         addr,
    input  logic [31:0]        din,
    input  logic [29:0]        pc,
    input  logic [HWINT_W-1:0] hwint,
    input  logic               exlset,
    input  logic               exlclr,
    output logic [31:0]        dout,
    output logic [29:0]        epc,
    output logic               intreq
);

    logic [HWINT_W-1:0] ip_q;    // registered copy of hwint
    logic [HWINT_W-1:0] ip_eff;  // IP as seen by Cause and the request logic
    logic [HWINT_W-1:0] im_q;
    logic               exl_q;
    logic               ie_q;
    logic [29:0]        epc_q;
    logic               ti;
    logic               sr_wr;
    logic               epc_wr;
    logic [31:0]        sr_rd;
    logic [31:0]        cause_rd;

    assign sr_wr  = we && (addr == CP0_SR);
    assign epc_wr = we && (addr == CP0_EPC);

`ifdef CP0_TIMER_EN
    logic [31:0] count_val;
    logic [31:0] compare_val;

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (we && (addr == CP0_COUNT)),
        .compare_we (we && (addr == CP0_COMPARE)),
        .din        (din),
        .count      (count_val),
        .compare    (compare_val),
        .ti         (ti)
    );

    // Timer shares the top hardware interrupt slot (IP[15], masked by IM[5]).
    assign ip_eff = ip_q | {ti, {(HWINT_W-1){1'b0}}};
`else
    assign ti     = 1'b0;
    assign ip_eff = ip_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ip_q  <= '0;
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            epc_q <= '0;
        end else begin
            ip_q <= hwint;

            if (sr_wr) begin
                im_q <= din[IM_LSB +: HWINT_W];
                ie_q <= din[IE_BIT];
            end

            // EXL: exception entry beats ERET, which beats a software write.
            if (exlset) begin
                exl_q <= 1'b1;
            end else if (exlclr) begin
                exl_q <= 1'b0;
            end else if (sr_wr) begin
                exl_q <= din[EXL_BIT];
            end

            if (exlset) begin
                epc_q <= pc;
            end else if (epc_wr) begin
                epc_q <= din[31:2];
            end
        end
    end

    always_comb begin
        sr_rd                       = '0;
        sr_rd[IM_LSB +: HWINT_W]    = im_q;
        sr_rd[EXL_BIT]              = exl_q;
        sr_rd[IE_BIT]               = ie_q;

        cause_rd                    = '0;
        cause_rd[IM_LSB +: HWINT_W] = ip_eff;
        cause_rd[TI_BIT]            = ti;
    end

    always_comb begin
        dout = '0;
        case (addr)
            CP0_SR:      dout = sr_rd;
            CP0_CAUSE:   dout = cause_rd;
            CP0_EPC:     dout = {epc_q, 2'b00};
            CP0_PRID:    dout = PRID_VAL;
`ifdef CP0_TIMER_EN
            CP0_COUNT:   dout = count_val;
            CP0_COMPARE: dout = compare_val;
`endif
            default:     dout = '0;
        endcase
    end

    // EXL suppresses the request while a handler runs, so the controller
    // cannot re-enter the interrupt state on the cycle after exlset.
    assign intreq = (|(ip_eff & im_q)) & ie_q & ~exl_q;
    assign epc    = epc_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// ---------------------------------------------------------------------------
// tb_cp0_regfile
// Directed bench for cp0_regfile. Driver tasks change inputs 1 ns after the
// rising edge and push expected values into a queue; a monitor on the
// falling edge pops every pending expectation and compares it against the
// selected DUT output. Timer checks are compiled only with CP0_TIMER_EN.
// ---------------------------------------------------------------------------
module tb_cp0_regfile;

    localparam logic [31:0] PRID = 32'h0002_0203;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [29:0] pc;
    logic [5:0]  hwint;
    logic        exlset;
    logic        exlclr;
    logic [31:0] dout;
    logic [29:0] epc;
    logic        intreq;

    cp0_regfile #(
        .PRID_VAL (PRID),
        .HWINT_W  (6)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .addr   (addr),
        .din    (din),
        .pc     (pc),
        .hwint  (hwint),
        .exlset (exlset),
        .exlclr (exlclr),
        .dout   (dout),
        .epc    (epc),
        .intreq (intreq)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          kind_q[$];   // 0 = dout, 1 = epc, 2 = intreq
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;

    logic [31:0] mon_exp;
    logic [31:0] mon_act;
    int          mon_kind;
    string       mon_name;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_kind = kind_q.pop_front();
            mon_name = name_q.pop_front();
            case (mon_kind)
                0:       mon_act = dout;
                1:       mon_act = {2'b00, epc};
                default: mon_act = {31'b0, intreq};
            endcase
            total++;
            if (mon_act !== mon_exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", mon_name, mon_act, mon_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        din  = d;
        tick();
        we   = 1'b0;
        din  = '0;
    endtask

    task automatic exp_dout(input string n, input logic [4:0] a, input logic [31:0] e);
        addr = a;
        exp_q.push_back(e);
        kind_q.push_back(0);
        name_q.push_back(n);
    endtask

    task automatic exp_epc(input string n, input logic [29:0] e);
        exp_q.push_back({2'b00, e});
        kind_q.push_back(1);
        name_q.push_back(n);
    endtask

    task automatic exp_intreq(input string n, input logic e);
        exp_q.push_back({31'b0, e});
        kind_q.push_back(2);
        name_q.push_back(n);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; we = 1'b0; addr = '0; din = '0; pc = '0;
        hwint = '0; exlset = 1'b0; exlclr = 1'b0;

        // Reset values
        tick();
        exp_dout("rst_sr", 5'd12, 32'h0); exp_intreq("rst_intreq", 1'b0); exp_epc("rst_epc", 30'h0);
        tick();
        exp_dout("rst_cause", 5'd13, 32'h0); tick();
        exp_dout("rst_epc_rd", 5'd14, 32'h0); tick();
        exp_dout("rst_prid", 5'd15, PRID); tick();
        rst = 1'b0;
        tick();

        // Enable IM[0] and IE
        mtc0(5'd12, 32'h0000_0401);
        exp_dout("sr_write", 5'd12, 32'h0000_0401); exp_intreq("no_int_yet", 1'b0);
        tick();

        // One-clock latency from hwint to intreq
        hwint = 6'b000001;
        exp_intreq("lat_before_edge", 1'b0);
        tick();
        exp_intreq("lat_one_clock", 1'b1); exp_dout("cause_ip0", 5'd13, 32'h0000_0400);
        tick();

        // Masked line
        hwint = 6'b000010;
        tick();
        exp_intreq("masked_line", 1'b0); exp_dout("cause_ip1", 5'd13, 32'h0000_0800);
        tick();

        // Interrupt entry
        hwint = 6'b000001;
        tick();
        exp_intreq("pre_entry", 1'b1);
        pc = 30'h0000_0C10; exlset = 1'b1;
        tick();
        exlset = 1'b0;
        exp_epc("entry_epc", 30'h0000_0C10); exp_intreq("entry_masks", 1'b0);
        exp_dout("entry_sr", 5'd12, 32'h0000_0403);
        tick();
        exp_intreq("handler_masked", 1'b0);

        // ERET
        exlclr = 1'b1;
        tick();
        exlclr = 1'b0;
        exp_intreq("eret_intreq", 1'b1); exp_dout("eret_sr", 5'd12, 32'h0000_0401);
        tick();

        // Collision: SR write with exlset
        we = 1'b1; addr = 5'd12; din = 32'h0; exlset = 1'b1; pc = 30'h0000_0123;
        tick();
        we = 1'b0; exlset = 1'b0;
        exp_dout("coll_sr", 5'd12, 32'h0000_0002); exp_epc("coll_epc", 30'h0000_0123);
        exp_intreq("coll_intreq", 1'b0);
        tick();

        // EPC written by MTC0
        mtc0(5'd14, 32'hDEAD_BEEF);
        exp_epc("mtc0_epc", 30'h37AB_6FBB); exp_dout("mtc0_epc_rd", 5'd14, 32'hDEAD_BEEC);
        tick();

        // Read-only / unmapped registers
        mtc0(5'd13, 32'hFFFF_FFFF);
        exp_dout("cause_ro", 5'd13, 32'h0000_0400); tick();
        mtc0(5'd15, 32'h0);
        exp_dout("prid_ro", 5'd15, PRID); tick();
        mtc0(5'd5, 32'h1234_5678);
        exp_dout("unmapped", 5'd5, 32'h0); tick();

        // SR unimplemented bits read zero
        mtc0(5'd12, 32'hFFFF_FFFF);
        exp_dout("sr_all_ones", 5'd12, 32'h0000_FC03); exp_intreq("sr_exl_masks", 1'b0);
        tick();

        // exlclr beats MTC0 for EXL
        we = 1'b1; addr = 5'd12; din = 32'h0000_0403; exlclr = 1'b1;
        tick();
        we = 1'b0; exlclr = 1'b0;
        exp_dout("clr_over_wr", 5'd12, 32'h0000_0401); exp_intreq("clr_over_wr_int", 1'b1);
        tick();

        // Asynchronous reset mid-handler: intreq drops before any edge
        exp_intreq("pre_async_rst", 1'b1);
        tick();
        rst = 1'b1;
        exp_intreq("async_rst_int", 1'b0); exp_dout("async_rst_sr", 5'd12, 32'h0);
        tick();
        exp_epc("async_rst_epc", 30'h0);
        tick();
        rst = 1'b0; hwint = '0;
        tick();

        // exlset beats exlclr
        exlset = 1'b1; exlclr = 1'b1; pc = 30'h0000_0077;
        tick();
        exlset = 1'b0; exlclr = 1'b0;
        exp_dout("set_over_clr", 5'd12, 32'h0000_0002); exp_epc("set_over_clr_epc", 30'h0000_0077);
        tick();
        exlclr = 1'b1;
        tick();
        exlclr = 1'b0;

`ifdef CP0_TIMER_EN
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        exp_dout("ti_count0", 5'd13, 32'h0);
        tick(); tick(); tick(); tick();
        exp_dout("ti_count4", 5'd13, 32'h0);
        tick();
        exp_dout("ti_set", 5'd13, 32'h4000_8000);
        tick();
        mtc0(5'd12, 32'h0000_8001);
        exp_intreq("ti_intreq", 1'b1);
        tick();
        mtc0(5'd11, 32'd100);
        exp_dout("ti_clear", 5'd13, 32'h0); exp_intreq("ti_clear_int", 1'b0);
        tick();
        mtc0(5'd9, 32'h0000_0010);
        exp_dout("count_wr", 5'd9, 32'h0000_0010); tick();
        exp_dout("compare_rd", 5'd11, 32'd100); tick();
        mtc0(5'd9, 32'hFFFF_FFFF);
        tick();
        exp_dout("count_wrap", 5'd9, 32'h0); tick();
`else
        mtc0(5'd9, 32'h0000_0055);
        exp_dout("no_count", 5'd9, 32'h0); tick();
        mtc0(5'd11, 32'd5);
        exp_dout("no_compare", 5'd11, 32'h0); tick();
        mtc0(5'd12, 32'h0000_8001);
        repeat (6) tick();
        exp_dout("no_ti", 5'd13, 32'h0); exp_intreq("no_ti_int", 1'b0);
        tick();
`endif

        // Drain and report
        tick();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 for the multicycle MIPS core.
- Holds SR, Cause, EPC and PRId, and turns external device interrupt lines into the single `intreq` signal that the main controller samples in its final execute states.
- Consumes the controller's `cp0_wen` (MTC0 in S5), `exlset` (interrupt state S10) and `exlclr` (ERET) strobes.
- Supplies MFC0 read data and the ERET return address to the datapath.

Parameters:
- PRID_VAL, 32'h0002_0203, constant returned for register 15 (PRId).
- HWINT_W, 6, number of hardware interrupt lines, mapped to Cause/SR bits [15:10].

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- we  in  1  MTC0 write strobe (controller `cp0_wen`)
- addr  in  5  CP0 register index (instruction rd field)
- din  in  32  MTC0 write data (GPR rt)
- pc  in  30  current PC[31:2], i.e. address of the next instruction to execute
- hwint  in  HWINT_W  level-sensitive device interrupt requests
- exlset  in  1  enter-exception strobe (controller S10)
- exlclr  in  1  ERET strobe
- dout  out  32  MFC0 read data
- epc  out  30  EPC[31:2], the PC load value for ERET
- intreq  out  1  interrupt request to controller

Behaviour:
- Register map:
  - 12 = SR: IM = bits[15:10], EXL = bit[1], IE = bit[0], all other bits read 0.
  - 13 = Cause: IP = bits[15:10], all other bits read 0, read-only.
  - 14 = EPC: {epc, 2'b00}.
  - 15 = PRId: PRID_VAL.
  - Any other index reads 32'h0, and writes to it are ignored.
- Reset: IM=0, EXL=0, IE=0, IP=0, EPC=0.
  - dout therefore reads 0 for registers 12, 13 and 14.
  - epc = 0 and intreq = 0.
- dout is combinational from addr and the current register values, with zero read latency. MFC0 samples it in controller S3.
- IP sampling: IP <= hwint every clock edge. IP is not writable and is a 1-cycle registered copy of hwint.
- intreq = (|(IP & IM)) & IE & ~EXL, combinational from registers.
  - Latency from hwint rising to intreq: 1 clock.
  - EXL masks further requests while the handler runs.
- MTC0 (we=1) updates at the clock edge:
  - addr 12 loads IM, EXL and IE from din[15:10], din[1] and din[0].
  - addr 14 loads epc from din[31:2].
  - addr 13 and addr 15 are ignored.
- exlset=1 at the clock edge: EXL <= 1 and epc <= pc.
- exlclr=1 at the clock edge: EXL <= 0.
- Priority for the EXL bit: exlset > exlclr > MTC0 write.
- Priority for EPC: exlset > MTC0 write.
- Simultaneous cases:
  - exlset with we to SR: IM and IE take din, EXL = 1.
  - exlset with exlclr: EXL = 1.
- intreq deasserts in the cycle after exlset because EXL is now 1, so the controller cannot re-enter S10 back-to-back.
- hwint pulses shorter than one clock may be missed; devices must hold the request until it is serviced.
- Asynchronous reset mid-handler clears EXL and IE. intreq drops immediately.

Optional Feature:
- Macro CP0_TIMER_EN.
- When defined, add:
  - Count (register 9): 32-bit, increments every clock, wraps at 32'hFFFF_FFFF -> 0, writable via MTC0.
  - Compare (register 11): 32-bit, MTC0-writable.
  - TI pending flag: set when Count == Compare and Compare != 0; cleared by any MTC0 write to Compare.
- TI is ORed into IP[15], so it is masked by IM[5].
- Cause reads TI at bit 30.
- Count and Compare reset to 0. A write to Count takes precedence over the increment.
- When the macro is undefined, registers 9 and 11 read 0, writes to them are ignored, and no TI logic exists.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - CP0 register index constants: CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15, CP0_COUNT=9, CP0_COMPARE=11.
  - SR and Cause bit-position constants: IM_LSB=10, EXL_BIT=1, IE_BIT=0, TI_BIT=30.
- One sub-module, cp0_timer (Count/Compare/TI), is instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset: assert rst, read addr 12/13/14/15 -> 0/0/0/32'h0002_0203; intreq=0, epc=0.
- MTC0 SR = 32'h0000_0401, then hwint=6'b000001:
  - intreq=1 exactly one clock after hwint rises.
  - Cause reads 32'h0000_0400.
  - hwint=6'b000010 instead -> intreq stays 0 (masked by IM).
- Interrupt entry: intreq=1, pc=30'h0000_0C10, pulse exlset:
  - epc=30'h0000_0C10.
  - SR reads 32'h0000_0403.
  - intreq=0 next cycle despite hwint still high.
- ERET: pulse exlclr with hwint still 1 -> EXL=0, intreq=1 in the same cycle the EXL clear takes effect.
- Collision: same edge with we=1, addr=12, din=0, and exlset=1 -> SR reads 32'h0000_0002; epc=pc.
- CP0_TIMER_EN:
  - Write Compare=5, then Count=0.
  - After 5 clocks, Cause bit 30 = 1.
  - With SR = 32'h0000_8001, intreq=1.
  - Writing Compare clears bit 30.
